// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded controls, operands and flags, with stall and flush.
// Optional macro ID_EX_FORWARDING_EN adds src1/src2 register indices for the EX forwarding unit.
module id_ex_stage_reg #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      freeze,
    input  logic [8:0]                controls_in,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     val_rn_in,
    input  logic [WORD_WIDTH-1:0]     val_rm_in,
    input  logic                      imm_in,
    input  logic [11:0]               shift_operand_in,
    input  logic [23:0]               signed_imm_24_in,
    input  logic [REG_ADDR_WIDTH-1:0] dest_in,
    input  logic [3:0]                status_in,
    input  logic                      valid_in,
`ifdef ID_EX_FORWARDING_EN
    input  logic [REG_ADDR_WIDTH-1:0] src1_in,
    input  logic [REG_ADDR_WIDTH-1:0] src2_in,
    output logic [REG_ADDR_WIDTH-1:0] src1_out,
    output logic [REG_ADDR_WIDTH-1:0] src2_out,
`endif
    output logic                      wb_en_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic [3:0]                exe_cmd_out,
    output logic                      b_out,
    output logic                      s_out,
    output logic [WORD_WIDTH-1:0]     pc_out,
    output logic [WORD_WIDTH-1:0]     val_rn_out,
    output logic [WORD_WIDTH-1:0]     val_rm_out,
    output logic                      imm_out,
    output logic [11:0]               shift_operand_out,
    output logic [23:0]               signed_imm_24_out,
    output logic [REG_ADDR_WIDTH-1:0] dest_out,
    output logic [3:0]                status_out,
    output logic                      valid_out
);

    // An empty decode slot must not write back, touch memory, branch or set flags.
    logic [8:0] ctrl_p0;
    assign ctrl_p0 = valid_in ? controls_in : (controls_in & 9'b0_0_0_1111_0_0);

    logic                      wb_en_p1, mem_read_p1, mem_write_p1, b_p1, s_p1;
    logic [3:0]                exe_cmd_p1;
    logic [WORD_WIDTH-1:0]     pc_p1, val_rn_p1, val_rm_p1;
    logic                      imm_p1;
    logic [11:0]               shift_operand_p1;
    logic [23:0]               signed_imm_24_p1;
    logic [REG_ADDR_WIDTH-1:0] dest_p1;
    logic [3:0]                status_p1;
    logic                      vld_p1;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wb_en_p1         <= 1'b0;
            mem_read_p1      <= 1'b0;
            mem_write_p1     <= 1'b0;
            exe_cmd_p1       <= '0;
            b_p1             <= 1'b0;
            s_p1             <= 1'b0;
            pc_p1            <= '0;
            val_rn_p1        <= '0;
            val_rm_p1        <= '0;
            imm_p1           <= 1'b0;
            shift_operand_p1 <= '0;
            signed_imm_24_p1 <= '0;
            dest_p1          <= '0;
            status_p1        <= '0;
            vld_p1           <= 1'b0;
        end else if (!freeze) begin
            wb_en_p1         <= ctrl_p0[8];
            mem_read_p1      <= ctrl_p0[7];
            mem_write_p1     <= ctrl_p0[6];
            exe_cmd_p1       <= ctrl_p0[5:2];
            b_p1             <= ctrl_p0[1];
            s_p1             <= ctrl_p0[0];
            pc_p1            <= pc_in;
            val_rn_p1        <= val_rn_in;
            val_rm_p1        <= val_rm_in;
            imm_p1           <= imm_in;
            shift_operand_p1 <= shift_operand_in;
            signed_imm_24_p1 <= signed_imm_24_in;
            dest_p1          <= dest_in;
            status_p1        <= status_in;
            vld_p1           <= valid_in;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    logic [REG_ADDR_WIDTH-1:0] src1_p1, src2_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            src1_p1 <= '0;
            src2_p1 <= '0;
        end else if (!freeze) begin
            src1_p1 <= src1_in;
            src2_p1 <= src2_in;
        end
    end

    assign src1_out = src1_p1;
    assign src2_out = src2_p1;
`endif

    assign wb_en_out         = wb_en_p1;
    assign mem_read_out      = mem_read_p1;
    assign mem_write_out     = mem_write_p1;
    assign exe_cmd_out       = exe_cmd_p1;
    assign b_out             = b_p1;
    assign s_out             = s_p1;
    assign pc_out            = pc_p1;
    assign val_rn_out        = val_rn_p1;
    assign val_rm_out        = val_rm_p1;
    assign imm_out           = imm_p1;
    assign shift_operand_out = shift_operand_p1;
    assign signed_imm_24_out = signed_imm_24_p1;
    assign dest_out          = dest_p1;
    assign status_out        = status_p1;
    assign valid_out         = vld_p1;

endmodule
